// File: rtl/dmem_rmw_ctrl.sv
// dmem_rmw_ctrl: word-organised data memory with sign/zero-extending loads and
// byte/half stores via read-modify-write. Misalignment trapping: DMEM_MISALIGN_TRAP_EN.
module dmem_rmw_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [1:0]       req_bhw,
  input  logic             req_sign,
  input  logic             req_we,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int AW = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          addr_q;
  logic [WIDTH-1:0]       wdata_q;
  logic [1:0]             bhw_q;
  logic                   sign_q;
  logic                   we_q;
  logic [WIDTH-1:0]       rd_q;
  logic [WIDTH-1:0]       wr_word;
  logic [WIDTH-1:0]       ld_word;
  logic [WIDTH-1:0]       mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]  idx;
  logic [7:0]             sel_b;
  logic [15:0]            sel_h;
  logic                   misal_in;
  logic                   misal_q;
  logic                   accept;
  logic                   unused_addr_hi;

  // Address bits above the array index wrap around and are never stored.
  assign unused_addr_hi = ^req_addr[WIDTH-1:AW];
  assign idx            = addr_q[AW-1:2];
  assign accept         = (state_q == IDLE) && req_valid;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misal_in = ((req_bhw == 2'd1) && req_addr[0]) ||
                    (req_bhw[1] && (req_addr[1:0] != 2'b00));
  assign misal_q  = ((bhw_q == 2'd1) && addr_q[0]) ||
                    (bhw_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign misal_in = 1'b0;
  assign misal_q  = 1'b0;
`endif

  // Request capture and state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      bhw_q   <= '0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
        bhw_q   <= req_bhw;
        sign_q  <= req_sign;
        we_q    <= req_we;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misal_in)                state_d = RSP;
          else if (req_we && req_bhw[1]) state_d = WR;
          else                         state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : RSP;
      WR:      state_d = RSP;
      RSP:     state_d = rsp_ready ? IDLE : RSP;
      default: state_d = IDLE;
    endcase
  end

  // Array has no reset; read registers data in RD, write happens only in WR.
  always_ff @(posedge clk) begin
    if (state_q == WR) mem[idx] <= wr_word;
    if (state_q == RD) rd_q <= mem[idx];
  end

  assign sel_b = rd_q[{addr_q[1:0], 3'b000} +: 8];
  assign sel_h = rd_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    wr_word = rd_q;
    if (bhw_q[1])
      wr_word = wdata_q;
    else if (bhw_q == 2'd0)
      wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    ld_word = rd_q;
    if (bhw_q == 2'd0)
      ld_word = {{(WIDTH-8){sign_q & sel_b[7]}}, sel_b};
    else if (bhw_q == 2'd1)
      ld_word = {{(WIDTH-16){sign_q & sel_h[15]}}, sel_h};
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_err   = (state_q == RSP) && misal_q;
  assign rsp_rdata = ((state_q == RSP) && !we_q && !misal_q) ? ld_word : '0;

endmodule

// File: doc/dmem_rmw_ctrl.md
DMEM_RMW_CTRL -- requirements
Module: dmem_rmw_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, log2 of word count in internal data array.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready at clk edge.
REQ-007 SHALL have port req_addr  input  WIDTH  byte address.
REQ-008 SHALL have port req_wdata  input  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port req_bhw  input  2  size: 0 byte, 1 halfword, 2 word, 3 treated as word.
REQ-010 SHALL have port req_sign  input  1  sign-extend load result.
REQ-011 SHALL have port req_we  input  1  1 store, 0 load.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when rsp_valid & rsp_ready at clk edge.
REQ-014 SHALL have port rsp_rdata  output  WIDTH  load result, extended; 0 for stores.
REQ-015 SHALL have port rsp_err  output  1  access rejected (misaligned, see Configuration).

Function
REQ-016 SHALL hold 2**DEPTH_LOG2 words; word index = req_addr[DEPTH_LOG2+1:2], higher address bits ignored (wrap-around).
REQ-017 SHALL read the array synchronously: data available the cycle after the read-enable cycle.
REQ-018 SHALL implement FSM states IDLE, RD, WR, RSP; req_ready = 1 only in IDLE.
REQ-019 SHALL latch addr, wdata, bhw, sign, we on acceptance in IDLE.
REQ-020 Load: IDLE -> RD -> RSP; rsp_valid asserted 2 cycles after acceptance edge.
REQ-021 Store word (bhw 2/3): IDLE -> WR -> RSP; full word written in WR, no read.
REQ-022 Store byte/half: IDLE -> RD -> WR -> RSP; read word, merge new lane(s) into old word, write in WR; unselected bytes SHALL be unchanged.
REQ-023 Byte lane = addr[1:0] (lane 0 = bits 7:0); half lane = addr[1] (0 = bits 15:0).
REQ-024 Load extraction: selected byte/half zero-extended, or sign-extended when req_sign=1 and its MSB=1; word returned unmodified.
REQ-025 RSP SHALL hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready; on handshake go to IDLE next cycle (no back-to-back acceptance in RSP).
REQ-026 rsp_valid SHALL be 0 in IDLE, RD, WR.
REQ-027 Array write SHALL occur only in WR state, exactly once per store.

Reset
REQ-028 On rst: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, latched request cleared; req_ready 1 once rst deasserts.
REQ-029 rst in RD SHALL abort with no array write; rst in RSP SHALL drop pending response.
REQ-030 Array contents SHALL NOT be reset.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-032 Defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE -> RSP next cycle with rsp_err=1, rsp_rdata=0, no array access.
REQ-033 Undefined: rsp_err tied 0; half ignores addr[0], word ignores addr[1:0].

Verification
REQ-034 Store word 0x11223344 at 0x10, load word 0x10 -> rsp_rdata 0x11223344, rsp_valid 2 cycles after acceptance.
REQ-035 Then store byte 0xAA at 0x12, load word 0x10 -> 0x11AA3344; load byte 0x12 sign=1 -> 0xFFFFFFAA, sign=0 -> 0x000000AA.
REQ-036 Store half 0x8001 at 0x16 over word 0, load half 0x16 sign=1 -> 0xFFFF8001; load word 0x14 -> 0x80010000.
REQ-037 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0, new req_valid ignored.
REQ-038 Assert rst during RD of byte store to 0x10 -> word 0x10 unchanged, rsp_valid 0, req_ready 1 after release.
REQ-039 Load word 0x13 -> with DMEM_MISALIGN_TRAP_EN rsp_err 1, rdata 0; without, returns word at 0x10.
